fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter BUF_DEPTH, default 2, SHALL be the instruction buffer depth in entries (legal range 2..8).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: asynchronous, active-low (0 = in reset).
REQ-004 entry  input  64  SHALL be the program entry PC, loaded into the fetch PC during reset.
REQ-005 redirect_valid  input  1  SHALL request a PC redirect this cycle.
REQ-006 redirect_pc  input  64  SHALL be the new fetch PC when redirect_valid=1.
REQ-007 ic_req_valid  output  1  SHALL indicate a valid icache fetch request.
REQ-008 ic_req_addr  output  64  SHALL be the fetch address; must be stable while ic_req_valid=1 and ic_req_ready=0.
REQ-009 ic_req_ready  input  1  SHALL be the icache accept signal; request handshake is ic_req_valid & ic_req_ready.
REQ-010 ic_resp_valid  input  1  SHALL be a one-cycle pulse returning the instruction for the oldest accepted request.
REQ-011 ic_resp_inst  input  32  SHALL be the returned instruction word.
REQ-012 out_valid  output  1  SHALL be high when the buffer head holds an instruction for the IF/ID register.
REQ-013 out_inst  output  32  SHALL be the buffer-head instruction.
REQ-014 out_pc  output  64  SHALL be the PC of the buffer-head instruction.
REQ-015 out_ready  input  1  SHALL be downstream accept; pop occurs on out_valid & out_ready.
REQ-016 halted  output  1  SHALL be high once the fetch stage has stopped on a zero instruction.

Function
REQ-017 State machine SHALL have states IDLE, REQ, WAIT, STALE, HALT.
REQ-018 IDLE SHALL transition to REQ on the first clock edge after reset deasserts.
REQ-019 In REQ, ic_req_valid SHALL be 1 and ic_req_addr SHALL equal the fetch PC; on handshake the state SHALL go to WAIT and PC SHALL advance by 4 (64-bit wrap-around, no flag).
REQ-020 REQ SHALL only be entered when buffer occupancy < BUF_DEPTH, so every accepted response has a guaranteed slot; otherwise the stage SHALL hold in WAIT-exit until a pop frees a slot.
REQ-021 At most one request SHALL be outstanding.
REQ-022 In WAIT, ic_resp_valid SHALL push {ic_resp_inst, request PC} into the buffer in the same cycle; out_valid SHALL rise the following cycle (1-cycle response-to-output latency).
REQ-023 After a push in WAIT, next state SHALL be REQ if space remains (counting a same-cycle pop), else WAIT-exit hold per REQ-020.
REQ-024 A pushed instruction equal to 32'h0000_0000 SHALL be buffered normally, set halted=1 next cycle, and move to HALT; no requests SHALL be issued in HALT.
REQ-025 Buffer SHALL be a circular FIFO; simultaneous push and pop SHALL keep occupancy unchanged; pop when empty and push when full SHALL not occur and are asserted as errors in simulation.
REQ-026 redirect_valid SHALL have priority over every other event in the same cycle: buffer flushed (out_valid=0 next cycle), PC loaded with redirect_pc, halted cleared.
REQ-027 Redirect in REQ without handshake SHALL go to REQ with the new PC (ic_req_valid may stay high with the new address; only case where the address changes unaccepted).
REQ-028 Redirect in REQ with same-cycle handshake, or in WAIT without ic_resp_valid, SHALL go to STALE; redirect in WAIT with ic_resp_valid SHALL discard that response and go to REQ.
REQ-029 In STALE, ic_req_valid SHALL be 0 and the next ic_resp_valid SHALL be discarded (not pushed), then go to REQ.
REQ-030 Redirect in HALT or IDLE SHALL go to REQ.

Reset
REQ-031 While reset=0: state=IDLE, PC=entry, buffer empty, ic_req_valid=0, out_valid=0, halted=0, regardless of other inputs.
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request; the icache is reset concurrently so no stale response is expected.

Verification
REQ-033 entry=0x1000, icache 1-cycle response, out_ready=1 -> ic_req_addr 0x1000, 0x1004, 0x1008 in order; out_pc matches each out_inst.
REQ-034 out_ready=0, BUF_DEPTH=2 -> exactly 2 entries buffered, no third request; ic_req_valid returns after one pop.
REQ-035 ic_resp_inst=0x0 at PC 0x100C -> delivered with out_pc=0x100C, halted=1, no further ic_req_valid; redirect to 0x2000 then clears halted and fetches 0x2000.
REQ-036 Redirect to 0x3000 while WAIT on 0x1004 -> 0x1004 response discarded, next request 0x3000, buffer flushed.
REQ-037 ic_req_ready held 0 for 5 cycles -> ic_req_addr stable at 0x1000 throughout.
REQ-038 Reset pulsed low mid-WAIT with entry=0x4000 -> all outputs 0 during reset; first request after release is 0x4000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding icache requester feeding a circular
// instruction buffer, with redirect, stale-response discard and halt-on-zero.
module fetch_stage #(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] entry,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ic_req_valid,
    output logic [63:0] ic_req_addr,
    input  logic        ic_req_ready,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    output logic        halted
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StStale,
        StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [63:0]     req_pc_q, req_pc_d;
    logic            pend_q, pend_d;
    logic            halted_q, halted_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     inst_mem_q [BUF_DEPTH];
    logic [63:0]     pc_mem_q   [BUF_DEPTH];

    logic push;
    logic pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ic_req_valid = (state_q == StReq);
    assign ic_req_addr  = ic_req_valid ? pc_q : '0;
    assign out_valid    = (count_q != '0);
    assign out_inst     = out_valid ? inst_mem_q[head_q] : '0;
    assign out_pc       = out_valid ? pc_mem_q[head_q] : '0;
    assign halted       = halted_q;

    // A response is only accepted in WAIT with a live request and no redirect.
    assign push = !redirect_valid && (state_q == StWait) && pend_q && ic_resp_valid;
    assign pop  = out_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        pend_d   = pend_q;
        halted_d = halted_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            pend_d   = 1'b0;
            state_d  = StReq;
            unique case (state_q)
                StReq:   if (ic_req_ready) state_d = StStale;
                StWait:  if (pend_q && !ic_resp_valid) state_d = StStale;
                StStale: if (!ic_resp_valid) state_d = StStale;
                default: ;
            endcase
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (ic_req_ready) begin
                        state_d  = StWait;
                        pend_d   = 1'b1;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 64'd4;
                    end
                end
                // pend_q=0 in WAIT is the hold for a free buffer slot.
                StWait: begin
                    if (pend_q) begin
                        if (ic_resp_valid) begin
                            pend_d = 1'b0;
                            if (ic_resp_inst == 32'h0) begin
                                halted_d = 1'b1;
                                state_d  = StHalt;
                            end else if (count_d < CntW'(BUF_DEPTH)) begin
                                state_d = StReq;
                            end
                        end
                    end else if (count_d < CntW'(BUF_DEPTH)) begin
                        state_d = StReq;
                    end
                end
                StStale: if (ic_resp_valid) state_d = StReq;
                StHalt:  ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            pc_q     <= entry;
            req_pc_q <= '0;
            pend_q   <= 1'b0;
            halted_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            pend_q   <= pend_d;
            halted_q <= halted_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[tail_q] <= ic_resp_inst;
            pc_mem_q[tail_q]   <= req_pc_q;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            assert (!(push && count_q == CntW'(BUF_DEPTH)))
            else $error("fetch_stage: push into full buffer");
            assert (!(pop && count_q == '0))
            else $error("fetch_stage: pop from empty buffer");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an icache/consumer model plus an expected-output
// queue derived from the fetch rules (sequential PCs, redirect flush, stale discard, halt).
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ic_req_valid;
    logic [63:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_inst;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_ready;
    logic        halted;

    fetch_stage #(.BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_inst   (ic_resp_inst),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus knobs
    int          rdy_pct, ordy_pct, redir_pct, zero_pct, lat_min, lat_max;
    logic [63:0] zero_addr;
    bit          force_redir;
    logic [63:0] forced_pc;

    // Reference model state
    ent_t        exp_q[$];
    logic [63:0] hs_log[$];
    logic [63:0] m_pc;
    logic [63:0] last_pop_pc;
    bit          m_halted, pend, pend_stale;
    logic [63:0] pend_addr;
    int          pend_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [63:0] e, input int n);
        @(negedge clk);
        reset          = 1'b0;
        entry          = e;
        redirect_valid = 1'b0;
        redirect_pc    = {$urandom, $urandom};
        ic_resp_valid  = 1'b0;
        ic_req_ready   = 1'($urandom);
        out_ready      = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check("rst_req_valid", ic_req_valid, 0);
            check("rst_req_addr", ic_req_addr, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_inst", out_inst, 0);
            check("rst_out_pc", out_pc, 0);
            check("rst_halted", halted, 0);
        end
        exp_q.delete();
        hs_log.delete();
        m_pc       = e;
        m_halted   = 0;
        pend       = 0;
        pend_stale = 0;
        ic_req_ready = 1'b0;
        reset      = 1'b1;
    endtask

    task automatic cycle();
        bit   hs, pop, rsp, rsp_good;
        ent_t e;
        @(negedge clk);
        redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
        if (force_redir) redirect_pc = forced_pc;
        else if ($urandom_range(9) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        else redirect_pc = {$urandom, $urandom} & ~64'h3;
        force_redir   = 0;
        ic_req_ready  = ($urandom_range(99) < rdy_pct);
        out_ready     = ($urandom_range(99) < ordy_pct);
        ic_resp_valid = 1'b0;
        ic_resp_inst  = $urandom;
        if (pend) begin
            if (pend_lat <= 1) begin
                ic_resp_valid = 1'b1;
                if (pend_addr == zero_addr || $urandom_range(99) < zero_pct) ic_resp_inst = 32'h0;
                else ic_resp_inst = $urandom | 32'h1;
            end else begin
                pend_lat--;
            end
        end
        #1;
        check("req_valid", ic_req_valid, (!pend && !m_halted && exp_q.size() < DEPTH));
        if (ic_req_valid) check("req_addr", ic_req_addr, m_pc);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (out_valid && exp_q.size() != 0) begin
            check("out_inst", out_inst, exp_q[0].inst);
            check("out_pc", out_pc, exp_q[0].pc);
        end
        check("halted", halted, m_halted);

        hs  = ic_req_valid && ic_req_ready;
        pop = out_valid && out_ready;
        rsp = ic_resp_valid;
        rsp_good = rsp && !pend_stale && !redirect_valid;
        if (hs) hs_log.push_back(ic_req_addr);
        if (rsp) pend = 0;
        if (redirect_valid) begin
            exp_q.delete();
            m_halted = 0;
            if (hs) begin
                pend       = 1;
                pend_stale = 1;
                pend_addr  = m_pc;
                pend_lat   = $urandom_range(lat_max, lat_min);
            end else if (pend) begin
                pend_stale = 1;
            end
            m_pc = redirect_pc;
        end else begin
            if (pop && exp_q.size() != 0) begin
                last_pop_pc = exp_q[0].pc;
                void'(exp_q.pop_front());
            end
            if (rsp_good) begin
                e.inst = ic_resp_inst;
                e.pc   = pend_addr;
                exp_q.push_back(e);
                if (ic_resp_inst == 32'h0) m_halted = 1;
            end
            if (hs) begin
                pend       = 1;
                pend_stale = 0;
                pend_addr  = m_pc;
                pend_lat   = $urandom_range(lat_max, lat_min);
                m_pc       = m_pc + 64'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k = 0;
        while (hs_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check("hs_timeout", 64'(hs_log.size() >= n), 1);
    endtask

    task automatic set_knobs(input int rdy, input int ordy, input int lmin, input int lmax);
        rdy_pct   = rdy;
        ordy_pct  = ordy;
        lat_min   = lmin;
        lat_max   = lmax;
        redir_pct = 0;
        zero_pct  = 0;
        zero_addr = 64'h1;
    endtask

    initial begin
        reset = 1'b0; entry = 64'h1000; redirect_valid = 0; redirect_pc = 0;
        ic_req_ready = 0; ic_resp_valid = 0; ic_resp_inst = 0; out_ready = 0;
        force_redir = 0; forced_pc = 0; last_pop_pc = 0; pend_addr = 0; pend_lat = 0;
        set_knobs(100, 100, 1, 1);

        // Request held unaccepted, then in-order sequential fetch
        do_reset(64'h1000, 3);
        set_knobs(0, 100, 1, 1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("stall_addr", ic_req_addr, 64'h1000);
        end
        set_knobs(100, 100, 1, 1);
        wait_hs(3, 40);
        if (hs_log.size() >= 3) begin
            check("seq0", hs_log[0], 64'h1000);
            check("seq1", hs_log[1], 64'h1004);
            check("seq2", hs_log[2], 64'h1008);
        end

        // Buffer full: exactly DEPTH entries, no further request until a pop
        do_reset(64'h1000, 2);
        set_knobs(100, 0, 1, 1);
        run(12);
        check("full_hs_count", hs_log.size(), DEPTH);
        check("full_no_req", ic_req_valid, 0);
        ordy_pct = 100;
        run(1);
        ordy_pct = 0;
        run(1);
        check("req_after_pop", ic_req_valid, 1);

        // Halt on zero instruction, then restart by redirect
        do_reset(64'h1000, 2);
        set_knobs(100, 100, 1, 1);
        zero_addr = 64'h100C;
        run(15);
        check("halt_flag", halted, 1);
        check("halt_pop_pc", last_pop_pc, 64'h100C);
        check("halt_hs_count", hs_log.size(), 4);
        force_redir = 1;
        forced_pc   = 64'h2000;
        wait_hs(5, 20);
        if (hs_log.size() >= 5) check("halt_restart", hs_log[4], 64'h2000);
        check("halt_cleared", halted, 0);

        // Redirect while waiting on 0x1004: response discarded, buffer flushed
        do_reset(64'h1000, 2);
        set_knobs(100, 100, 3, 3);
        wait_hs(2, 40);
        force_redir = 1;
        forced_pc   = 64'h3000;
        cycle();
        wait_hs(3, 40);
        if (hs_log.size() >= 3) check("redir_addr", hs_log[2], 64'h3000);

        // Reset in the middle of a WAIT
        do_reset(64'h1000, 2);
        set_knobs(100, 100, 3, 3);
        wait_hs(1, 20);
        cycle();
        do_reset(64'h4000, 3);
        set_knobs(100, 100, 1, 1);
        wait_hs(1, 20);
        if (hs_log.size() >= 1) check("rst_first_req", hs_log[0], 64'h4000);

        // Randomized traffic
        set_knobs(70, 60, 1, 3);
        redir_pct = 4;
        zero_pct  = 2;
        run(1500);
        do_reset(64'h8000, 2);
        set_knobs(50, 40, 1, 4);
        redir_pct = 6;
        zero_pct  = 3;
        run(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
